// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types for the systolic array feeder.
// Default lane count, element width, state encoding.
package systolic_pkg;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef logic [DW-1:0] elem_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } feed_state_t;
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Vector-pair input stream into the feeder.
// Valid/ready handshake carrying N activation and N weight lanes.
interface systolic_skew_feeder_if #(
  parameter int N  = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW
);
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_w;

  modport master (
    output in_valid,
    output in_a,
    output in_w,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_w,
    output in_ready
  );
endinterface

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth lane delay, cleared on reset.
// Shifts every clock; the caller injects zeros for idle cycles.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DEPTH-1:0][DW-1:0] sr;

  // shift one stage per clock
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int k = 1; k < DEPTH; k++)
        sr[k] <= sr[k-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// Tile sequencer and triangular skew for the systolic array edges.
// Clears PEs, feeds k vector pairs, flushes 2N-1 cycles, pulses done.
module systolic_skew_feeder #(
  parameter int N    = systolic_pkg::N,
  parameter int DW   = systolic_pkg::DW,
  parameter int KMAX = 255,
  parameter int KW   = $clog2(KMAX+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         cfg_k,
  output logic                  busy,
  systolic_skew_feeder_if.slave s,
  output logic [N*DW-1:0]       a_out,
  output logic [N*DW-1:0]       w_out,
  output logic                  pe_clr,
  output logic                  tile_done
);
  import systolic_pkg::*;

  localparam int FW = $clog2(2*N);
  localparam logic [FW-1:0] FL_LAST = FW'(2*N-2);

  feed_state_t   st;
  feed_state_t   st_nx;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt;
  logic [FW-1:0] fl;
  logic          rdy;
  logic          hs;

  assign s.in_ready = rdy;
  assign hs = s.in_valid & rdy;

  // state register
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // tile length latch, feed and flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
      cnt <= '0;
      fl  <= '0;
    end else begin
      if (st == IDLE && start)
        k_q <= cfg_k;
      if (st == CLEAR)
        cnt <= '0;
      else if (hs)
        cnt <= cnt + 1'b1;
      if (st == FLUSH)
        fl <= fl + 1'b1;
      else
        fl <= '0;
    end
  end

  // next state and control outputs
  always_comb begin
    st_nx     = st;
    busy      = 1'b1;
    rdy       = 1'b0;
    pe_clr    = 1'b0;
    tile_done = 1'b0;
    unique case (st)
      IDLE: begin
        busy = 1'b0;
        if (start)
          st_nx = (cfg_k == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        pe_clr = 1'b1;
        st_nx  = FEED;
      end
      FEED: begin
        rdy = 1'b1;
        if (s.in_valid && cnt == k_q - 1'b1)
          st_nx = FLUSH;
      end
      FLUSH: begin
        if (fl == FL_LAST)
          st_nx = DONE;
      end
      DONE: begin
        tile_done = 1'b1;
        st_nx     = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_in;
    logic [DW-1:0] w_in;

    assign a_in = hs ? s.in_a[i*DW +: DW] : '0;
    assign w_in = hs ? s.in_w[i*DW +: DW] : '0;

    skew_delay_line #(.DEPTH(i+1), .DW(DW)) u_a (
      .clk (clk),
      .rst (rst),
      .d   (a_in),
      .q   (a_out[i*DW +: DW])
    );

    skew_delay_line #(.DEPTH(i+1), .DW(DW)) u_w (
      .clk (clk),
      .rst (rst),
      .d   (w_in),
      .q   (w_out[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder.
// Timestamp tile model, injection history, behavioural 4x4 MAC array.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int HL = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   cfg_k;
  logic            busy;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] w_out;
  logic            pe_clr;
  logic            tile_done;

  systolic_skew_feeder_if #(.N(N), .DW(DW)) ifc ();

  systolic_skew_feeder #(.N(N), .DW(DW), .KMAX(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_k     (cfg_k),
    .busy      (busy),
    .s         (ifc),
    .a_out     (a_out),
    .w_out     (w_out),
    .pe_clr    (pe_clr),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int last_rst = 0;
  logic [N*DW-1:0] ha [HL];
  logic [N*DW-1:0] hw [HL];
  logic [N*DW-1:0] oa [HL];
  logic [N*DW-1:0] ow [HL];

  bit act = 0;
  int kk, nfed, t_clr, t_feed, t_done;
  int exp_done_total = 0;
  int obs_done_total = 0;

  int t0, n_clr, n_rdy, n_dn, dn_off, clr_off;

  logic [N*DW-1:0] av [256];
  logic [N*DW-1:0] wv [256];

  logic [DW-1:0] S  [N][N];
  logic [DW-1:0] AR [N][N];
  logic [DW-1:0] WR [N][N];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic array_tick();
    logic [DW-1:0] nS [N][N];
    logic [DW-1:0] nA [N][N];
    logic [DW-1:0] nW [N][N];
    logic [DW-1:0] ai, wi;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ai = (j == 0) ? a_out[i*DW +: DW] : AR[i][j-1];
        wi = (i == 0) ? w_out[j*DW +: DW] : WR[i-1][j];
        if (pe_clr) begin
          nS[i][j] = '0; nA[i][j] = '0; nW[i][j] = '0;
        end else begin
          nS[i][j] = S[i][j] + ai * wi;
          nA[i][j] = ai;
          nW[i][j] = wi;
        end
      end
    S = nS; AR = nA; WR = nW;
  endtask

  task automatic step();
    bit wa, erdy, hs;
    logic [N*DW-1:0] ea, ew;
    int idx;
    @(negedge clk);
    if (rst) begin
      act = 0;
      last_rst = cyc;
      ha[cyc % HL] = '0;
      hw[cyc % HL] = '0;
    end else begin
      wa   = act;
      erdy = wa && t_feed >= 0 && cyc >= t_feed && nfed < kk;
      check("busy", busy, wa);
      check("in_ready", ifc.in_ready, erdy);
      check("pe_clr", pe_clr, wa && cyc == t_clr);
      check("tile_done", tile_done, wa && cyc == t_done);
      ea = '0;
      ew = '0;
      for (int i = 0; i < N; i++) begin
        idx = cyc - 1 - i;
        if (idx > last_rst) begin
          ea[i*DW +: DW] = ha[idx % HL][i*DW +: DW];
          ew[i*DW +: DW] = hw[idx % HL][i*DW +: DW];
        end
      end
      check("a_out", a_out, ea);
      check("w_out", w_out, ew);
      oa[cyc % HL] = a_out;
      ow[cyc % HL] = w_out;
      if (pe_clr) begin n_clr++; clr_off = cyc - t0; end
      if (ifc.in_ready) n_rdy++;
      if (tile_done) begin
        n_dn++; dn_off = cyc - t0; obs_done_total++;
      end
      hs = erdy && ifc.in_valid;
      ha[cyc % HL] = hs ? ifc.in_a : '0;
      hw[cyc % HL] = hs ? ifc.in_w : '0;
      if (hs) begin
        av[nfed] = ifc.in_a;
        wv[nfed] = ifc.in_w;
        nfed++;
        if (nfed == kk) t_done = cyc + 2*N;
      end
      if (wa && cyc == t_done) begin
        act = 0;
        exp_done_total++;
      end
      if (!wa && start) begin
        act  = 1;
        kk   = int'(cfg_k);
        nfed = 0;
        if (kk == 0) begin
          t_clr = -1; t_feed = -1; t_done = cyc + 1;
        end else begin
          t_clr = cyc + 1; t_feed = cyc + 2; t_done = -1;
        end
      end
      array_tick();
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input int vmode, input int amode);
    logic [5:0] pat;
    int f;
    pat = 6'b110101;
    f = n - 2;
    unique case (vmode)
      0: ifc.in_valid = 1'b1;
      1: ifc.in_valid = (f < 0) ? 1'b0 : (f < 6) ? pat[f] : 1'b1;
      default: ifc.in_valid = 1'($urandom_range(0, 1));
    endcase
    unique case (amode)
      0: begin
        ifc.in_a = 32'h04030201;
        ifc.in_w = 32'h1E140A00;
      end
      1: begin
        ifc.in_a = $urandom;
        ifc.in_w = (act && nfed < N) ? (32'h1 << (8*nfed)) : '0;
      end
      default: begin
        ifc.in_a = $urandom;
        ifc.in_w = $urandom;
      end
    endcase
  endtask

  task automatic run_tile(input int k, input int vmode, input int amode,
                          input bit rnd_start, input int rst_at);
    int n;
    n_clr = 0; n_rdy = 0; n_dn = 0; dn_off = -1; clr_off = -1;
    t0 = cyc;
    cfg_k = KW'(k);
    start = 1'b1;
    drive(0, vmode, amode);
    step();
    start = 1'b0;
    n = 1;
    while (act && n < 3000) begin
      if (n == rst_at) begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        break;
      end
      cfg_k = KW'($urandom);
      if (rnd_start) start = 1'($urandom_range(0, 1));
      drive(n, vmode, amode);
      step();
      n++;
    end
    if (act) check("timeout", 0, 1);
    start = 1'b0;
    ifc.in_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [DW-1:0] e;
    rst = 1'b1;
    start = 1'b0;
    cfg_k = '0;
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_w = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        S[i][j] = '0; AR[i][j] = '0; WR[i][j] = '0;
      end
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    run_tile(3, 0, 0, 0, -1);
    check("t2_clr_off", clr_off, 1);
    check("t2_done_off", dn_off, 12);
    check("t2_done_cnt", n_dn, 1);
    for (int i = 0; i < N; i++) begin
      check("t2_a_lane", oa[(t0+3+i) % HL][i*DW +: DW], i + 1);
      check("t2_w_lane", ow[(t0+3+i) % HL][i*DW +: DW], 10 * i);
    end

    run_tile(4, 1, 2, 0, -1);
    check("t3_feed_len", n_rdy, 6);
    check("t3_done_cnt", n_dn, 1);

    run_tile(0, 2, 2, 0, -1);
    check("t4_done_off", dn_off, 1);
    check("t4_clr_cnt", n_clr, 0);
    check("t4_rdy_cnt", n_rdy, 0);

    repeat (4) begin
      run_tile($urandom_range(1, 6), 2, 2, 1, -1);
      check("t5_done_cnt", n_dn, 1);
    end

    run_tile(5, 0, 2, 0, 4);
    check("t1_no_done", n_dn, 0);
    run_tile(2, 2, 2, 0, -1);
    check("t1_restart_done", n_dn, 1);

    for (int r = 0; r < 2; r++) begin
      run_tile(4, r == 0 ? 0 : 2, 1, 0, -1);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          e = '0;
          for (int q = 0; q < 4; q++)
            e = e + av[q][i*DW +: DW] * wv[q][j*DW +: DW];
          check("t6_pe_s", S[i][j], e);
        end
    end

    check("done_total", obs_done_total, exp_done_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
